axi_rr_mux: RTL and testbench

//  N-master to 1-slave mux for the core's simplified AXI bus (AW/W/B and AR/R channels, 3-bit port tag).

---
 rtl/axi_rr_mux_pkg.sv | 29 ++
 rtl/axi_rr_mux_rr_arbiter.sv | 38 +++
 rtl/axi_rr_mux.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_rr_mux.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rr_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rr_mux_pkg
//  Description : Shared types for the AXI round-robin master mux: response
//                and port-tag types, response codes, channel FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_rr_mux_pkg;

    typedef logic [1:0] resp_t;
    typedef logic [2:0] port_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_rr_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Scans req upward from ptr
//                with wraparound; the first asserted request wins.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N    = 2,
    parameter int IDXW = 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    gnt_oh,
    output logic [IDXW-1:0] gnt_idx
);

    logic [IDXW-1:0] cand;
    logic            found;

    // Priority scan starting at ptr; ptr itself is the highest priority slot
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDXW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt_oh[cand] = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rr_mux.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rr_mux
//  Description : N-master to 1-slave mux for the simplified AXI bus. Read and
//                write paths arbitrate independently (round-robin), each with
//                one outstanding transaction; responses go only to the owner.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_rr_mux
    import axi_rr_mux_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                                            clk,
    input  logic                                            rst,
    // master side, write
    input  logic  [NUM_MASTERS-1:0][AXI_ADDR_WIDTH-1:0]     m_awaddr,
    input  port_t [NUM_MASTERS-1:0]                         m_awport,
    input  logic  [NUM_MASTERS-1:0]                         m_awvalid,
    output logic  [NUM_MASTERS-1:0]                         m_awready,
    input  logic  [NUM_MASTERS-1:0][AXI_DATA_WIDTH-1:0]     m_wdata,
    input  logic  [NUM_MASTERS-1:0][AXI_DATA_WIDTH/8-1:0]   m_wstrb,
    input  logic  [NUM_MASTERS-1:0]                         m_wvalid,
    output logic  [NUM_MASTERS-1:0]                         m_wready,
    output logic  [NUM_MASTERS-1:0]                         m_bvalid,
    output resp_t [NUM_MASTERS-1:0]                         m_bresp,
    input  logic  [NUM_MASTERS-1:0]                         m_bready,
    // master side, read
    input  logic  [NUM_MASTERS-1:0][AXI_ADDR_WIDTH-1:0]     m_araddr,
    input  port_t [NUM_MASTERS-1:0]                         m_arport,
    input  logic  [NUM_MASTERS-1:0]                         m_arvalid,
    output logic  [NUM_MASTERS-1:0]                         m_arready,
    output logic  [NUM_MASTERS-1:0]                         m_rvalid,
    output logic  [NUM_MASTERS-1:0][AXI_DATA_WIDTH-1:0]     m_rdata,
    output resp_t [NUM_MASTERS-1:0]                         m_rresp,
    input  logic  [NUM_MASTERS-1:0]                         m_rready,
    // slave side, write
    output logic  [AXI_ADDR_WIDTH-1:0]                      s_awaddr,
    output port_t                                           s_awport,
    output logic                                            s_awvalid,
    input  logic                                            s_awready,
    output logic  [AXI_DATA_WIDTH-1:0]                      s_wdata,
    output logic  [AXI_DATA_WIDTH/8-1:0]                    s_wstrb,
    output logic                                            s_wvalid,
    input  logic                                            s_wready,
    input  logic                                            s_bvalid,
    input  resp_t                                           s_bresp,
    output logic                                            s_bready,
    // slave side, read
    output logic  [AXI_ADDR_WIDTH-1:0]                      s_araddr,
    output port_t                                           s_arport,
    output logic                                            s_arvalid,
    input  logic                                            s_arready,
    input  logic                                            s_rvalid,
    input  logic  [AXI_DATA_WIDTH-1:0]                      s_rdata,
    input  resp_t                                           s_rresp,
    output logic                                            s_rready
);

    localparam int              IDXW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_MASTERS - 1);

    // Pointer moves to the slot after the master that just finished, wrapping
    function automatic logic [IDXW-1:0] ptr_after(input logic [IDXW-1:0] g);
        return (g == LAST_IDX) ? '0 : g + 1'b1;
    endfunction

    r_state_e        r_state_q, r_state_d;
    logic [IDXW-1:0] rgnt_q, rgnt_d;
    logic [IDXW-1:0] rptr_q, rptr_d;

    w_state_e        w_state_q, w_state_d;
    logic [IDXW-1:0] wgnt_q, wgnt_d;
    logic [IDXW-1:0] wptr_q, wptr_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;

    logic [NUM_MASTERS-1:0] rd_win_oh, wr_win_oh;
    logic [IDXW-1:0]        rd_win_idx, wr_win_idx;

    rr_arbiter #(.N(NUM_MASTERS), .IDXW(IDXW)) u_rd_arb (
        .req     (m_arvalid),
        .ptr     (rptr_q),
        .gnt_oh  (rd_win_oh),
        .gnt_idx (rd_win_idx)
    );

    // Only AW requests compete for the write path; W alone cannot win a grant
    rr_arbiter #(.N(NUM_MASTERS), .IDXW(IDXW)) u_wr_arb (
        .req     (m_awvalid),
        .ptr     (wptr_q),
        .gnt_oh  (wr_win_oh),
        .gnt_idx (wr_win_idx)
    );

    // Read path next state: grant latch, address phase, data phase
    always_comb begin
        r_state_d = r_state_q;
        rgnt_d    = rgnt_q;
        rptr_d    = rptr_q;
        case (r_state_q)
            R_IDLE: begin
                if (|rd_win_oh) begin
                    rgnt_d    = rd_win_idx;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (s_arvalid && s_arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                if (s_rvalid && s_rready) begin
                    r_state_d = R_IDLE;
                    rptr_d    = ptr_after(rgnt_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read path routing: everything idles at zero outside the owning phase
    always_comb begin
        s_araddr  = '0;
        s_arport  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        case (r_state_q)
            R_ADDR: begin
                s_araddr          = m_araddr[rgnt_q];
                s_arport          = m_arport[rgnt_q];
                s_arvalid         = m_arvalid[rgnt_q];
                m_arready[rgnt_q] = s_arready;
            end
            R_DATA: begin
                m_rvalid[rgnt_q] = s_rvalid;
                m_rdata[rgnt_q]  = s_rdata;
                m_rresp[rgnt_q]  = s_rresp;
                s_rready         = m_rready[rgnt_q];
            end
            default: ;
        endcase
    end

    // Write path next state: AW and W complete independently before B
    always_comb begin
        w_state_d = w_state_q;
        wgnt_d    = wgnt_q;
        wptr_d    = wptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (w_state_q)
            W_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (|wr_win_oh) begin
                    wgnt_d    = wr_win_idx;
                    w_state_d = W_REQ;
                end
            end
            W_REQ: begin
                aw_done_d = aw_done_q | (s_awvalid && s_awready);
                w_done_d  = w_done_q  | (s_wvalid && s_wready);
                if (aw_done_d && w_done_d) w_state_d = W_RESP;
            end
            W_RESP: begin
                if (s_bvalid && s_bready) begin
                    w_state_d = W_IDLE;
                    wptr_d    = ptr_after(wgnt_q);
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write path routing; a channel that already handshook stops presenting valid
    always_comb begin
        s_awaddr  = '0;
        s_awport  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        case (w_state_q)
            W_REQ: begin
                s_awaddr          = m_awaddr[wgnt_q];
                s_awport          = m_awport[wgnt_q];
                s_awvalid         = m_awvalid[wgnt_q] & ~aw_done_q;
                m_awready[wgnt_q] = s_awready & ~aw_done_q;
                s_wdata           = m_wdata[wgnt_q];
                s_wstrb           = m_wstrb[wgnt_q];
                s_wvalid          = m_wvalid[wgnt_q] & ~w_done_q;
                m_wready[wgnt_q]  = s_wready & ~w_done_q;
            end
            W_RESP: begin
                m_bvalid[wgnt_q] = s_bvalid;
                m_bresp[wgnt_q]  = s_bresp;
                s_bready         = m_bready[wgnt_q];
            end
            default: ;
        endcase
    end

    // State registers for both paths; reset drops any in-flight beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rgnt_q    <= '0;
            rptr_q    <= '0;
            w_state_q <= W_IDLE;
            wgnt_q    <= '0;
            wptr_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rgnt_q    <= rgnt_d;
            rptr_q    <= rptr_d;
            w_state_q <= w_state_d;
            wgnt_q    <= wgnt_d;
            wptr_q    <= wptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rr_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_rr_mux
//  Description : Directed self-checking bench for axi_rr_mux (N=2 and N=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_rr_mux;
    import axi_rr_mux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- N=2 instance signals ----------------
    logic [1:0][63:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [1:0][7:0]  m_wstrb;
    logic [1:0][2:0]  m_awport, m_arport;
    logic [1:0][1:0]  m_bresp, m_rresp;
    logic [1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0] m_arvalid, m_arready, m_rvalid, m_rready;
    logic [63:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [7:0]  s_wstrb;
    logic [2:0]  s_awport, s_arport;
    logic [1:0]  s_bresp, s_rresp;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready;

    // ---------------- N=4 instance signals ----------------
    logic [3:0][63:0] m4_awaddr, m4_araddr, m4_wdata, m4_rdata;
    logic [3:0][7:0]  m4_wstrb;
    logic [3:0][2:0]  m4_awport, m4_arport;
    logic [3:0][1:0]  m4_bresp, m4_rresp;
    logic [3:0] m4_awvalid, m4_awready, m4_wvalid, m4_wready, m4_bvalid, m4_bready;
    logic [3:0] m4_arvalid, m4_arready, m4_rvalid, m4_rready;
    logic [63:0] s4_awaddr, s4_wdata, s4_araddr, s4_rdata;
    logic [7:0]  s4_wstrb;
    logic [2:0]  s4_awport, s4_arport;
    logic [1:0]  s4_bresp, s4_rresp;
    logic s4_awvalid, s4_awready, s4_wvalid, s4_wready, s4_bvalid, s4_bready;
    logic s4_arvalid, s4_arready, s4_rvalid, s4_rready;

    axi_rr_mux #(.NUM_MASTERS(2), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) u_dut2 (
        .clk(clk), .rst(rst),
        .m_awaddr(m_awaddr), .m_awport(m_awport), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arport(m_arport), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awport(s_awport), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arport(s_arport), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready)
    );

    axi_rr_mux #(.NUM_MASTERS(4), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) u_dut4 (
        .clk(clk), .rst(rst),
        .m_awaddr(m4_awaddr), .m_awport(m4_awport), .m_awvalid(m4_awvalid), .m_awready(m4_awready),
        .m_wdata(m4_wdata), .m_wstrb(m4_wstrb), .m_wvalid(m4_wvalid), .m_wready(m4_wready),
        .m_bvalid(m4_bvalid), .m_bresp(m4_bresp), .m_bready(m4_bready),
        .m_araddr(m4_araddr), .m_arport(m4_arport), .m_arvalid(m4_arvalid), .m_arready(m4_arready),
        .m_rvalid(m4_rvalid), .m_rdata(m4_rdata), .m_rresp(m4_rresp), .m_rready(m4_rready),
        .s_awaddr(s4_awaddr), .s_awport(s4_awport), .s_awvalid(s4_awvalid), .s_awready(s4_awready),
        .s_wdata(s4_wdata), .s_wstrb(s4_wstrb), .s_wvalid(s4_wvalid), .s_wready(s4_wready),
        .s_bvalid(s4_bvalid), .s_bresp(s4_bresp), .s_bready(s4_bready),
        .s_araddr(s4_araddr), .s_arport(s4_arport), .s_arvalid(s4_arvalid), .s_arready(s4_arready),
        .s_rvalid(s4_rvalid), .s_rdata(s4_rdata), .s_rresp(s4_rresp), .s_rready(s4_rready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_wstrb = '0; m_awport = '0; m_arport = '0;
        m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        m4_awaddr = '0; m4_araddr = '0; m4_wdata = '0; m4_wstrb = '0; m4_awport = '0; m4_arport = '0;
        m4_awvalid = '0; m4_wvalid = '0; m4_bready = '0; m4_arvalid = '0; m4_rready = '0;
        s4_awready = 1'b0; s4_wready = 1'b0; s4_bvalid = 1'b0; s4_bresp = '0;
        s4_arready = 1'b0; s4_rvalid = 1'b0; s4_rdata = '0; s4_rresp = '0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_awvalid", s_awvalid, 0);
        chk("rst_m_rvalid",  m_rvalid,  0);
        chk("rst_m_bvalid",  m_bvalid,  0);
        rst = 1'b0;

        // ---- single read from M0 ----
        m_arvalid = 2'b01; m_araddr[0] = 64'h80; m_arport[0] = 3'd5; m_rready = 2'b11;
        #1;
        chk("rd_idle_arready", m_arready, 0);
        tick();
        chk("rd_s_araddr",  s_araddr,  64'h80);
        chk("rd_s_arport",  s_arport,  5);
        chk("rd_s_arvalid", s_arvalid, 1);
        chk("rd_arready_lo", m_arready, 0);
        s_arready = 1'b1; #1;
        chk("rd_arready_hi", m_arready, 2'b01);
        tick();
        m_arvalid = 2'b00; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 64'hDEAD; #1;
        chk("rd_m_rvalid", m_rvalid, 2'b01);
        chk("rd_rdata0",   m_rdata[0], 64'hDEAD);
        chk("rd_rdata1",   m_rdata[1], 64'h0);
        chk("rd_s_rready", s_rready, 1);
        tick();
        chk("rd_done_rvalid",   m_rvalid, 0);
        chk("rd_idle_s_rready", s_rready, 0);
        s_rvalid = 1'b0;

        // ---- alternating reads, both masters requesting ----
        rst = 1'b1; tick(); rst = 1'b0;
        m_arvalid = 2'b11; m_araddr[0] = 64'h100; m_araddr[1] = 64'h200;
        s_arready = 1'b1; s_rvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_araddr",  s_araddr,  (i % 2 == 1) ? 64'h200 : 64'h100);
            chk("rr_arready", m_arready, (i % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            chk("rr_rvalid",  m_rvalid,  (i % 2 == 1) ? 2'b10 : 2'b01);
            tick();
        end
        m_arvalid = 2'b00; s_arready = 1'b0; s_rvalid = 1'b0;

        // ---- M1 write, W before AW ----
        m_wvalid = 2'b10; m_wdata[1] = 64'h1234_5678; m_wstrb[1] = 8'h0F;
        s_wready = 1'b1; s_awready = 1'b0; m_bready = 2'b11;
        tick();
        chk("wr_wonly_s_wvalid", s_wvalid, 0);
        tick();
        chk("wr_wonly_m_wready", m_wready, 0);
        m_awvalid = 2'b10; m_awaddr[1] = 64'h40; m_awport[1] = 3'd2;
        tick();
        chk("wr_s_wvalid",  s_wvalid,  1);
        chk("wr_s_wdata",   s_wdata,   64'h1234_5678);
        chk("wr_s_wstrb",   s_wstrb,   8'h0F);
        chk("wr_m_wready",  m_wready,  2'b10);
        chk("wr_s_awvalid", s_awvalid, 1);
        chk("wr_awready_lo", m_awready, 0);
        tick();
        chk("wr_wdone_s_wvalid", s_wvalid, 0);
        chk("wr_wdone_m_wready", m_wready, 0);
        tick();
        s_awready = 1'b1; #1;
        chk("wr_awready_hi", m_awready, 2'b10);
        chk("wr_s_awaddr",   s_awaddr,  64'h40);
        chk("wr_s_awport",   s_awport,  2);
        tick();
        m_awvalid = 2'b00; m_wvalid = 2'b00; s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1; s_bresp = RESP_OKAY; #1;
        chk("wr_m_bvalid", m_bvalid, 2'b10);
        chk("wr_m_bresp",  m_bresp[1], RESP_OKAY);
        m_bready = 2'b01; #1;
        chk("wr_bready_other", s_bready, 0);
        m_bready = 2'b10; #1;
        chk("wr_bready_own", s_bready, 1);
        tick();
        chk("wr_done_bvalid", m_bvalid, 0);
        chk("wr_idle_bready", s_bready, 0);
        s_bvalid = 1'b0;

        // ---- concurrent M0 read + M1 write ----
        m_arvalid = 2'b01; m_araddr[0] = 64'h300;
        m_awvalid = 2'b10; m_wvalid = 2'b10;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        tick();
        chk("cc_arready", m_arready, 2'b01);
        chk("cc_awready", m_awready, 2'b10);
        chk("cc_wready",  m_wready,  2'b10);
        tick();
        m_arvalid = 2'b00; m_awvalid = 2'b00; m_wvalid = 2'b00;
        s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 64'hBEEF; s_bvalid = 1'b1; s_bresp = RESP_SLVERR;
        m_rready = 2'b11; m_bready = 2'b11; #1;
        chk("cc_rvalid", m_rvalid, 2'b01);
        chk("cc_rdata",  m_rdata[0], 64'hBEEF);
        chk("cc_bvalid", m_bvalid, 2'b10);
        chk("cc_bresp",  m_bresp[1], RESP_SLVERR);
        tick();
        chk("cc_done_rvalid", m_rvalid, 0);
        chk("cc_done_bvalid", m_bvalid, 0);
        s_rvalid = 1'b0; s_bvalid = 1'b0;

        // ---- reset during read data phase ----
        m_arvalid = 2'b10; s_arready = 1'b1;
        tick();
        tick();
        m_arvalid = 2'b00; s_rvalid = 1'b1; #1;
        chk("rstmid_pre_rvalid", m_rvalid, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_rvalid",  m_rvalid,  0);
        chk("rstmid_s_rready", s_rready, 0);
        chk("rstmid_s_arvalid", s_arvalid, 0);
        chk("rstmid_arready", m_arready, 0);
        m_arvalid = 2'b11;
        tick();
        chk("rstmid_ptr0", m_arready, 2'b01);
        tick();
        m_arvalid = 2'b00;
        tick();
        s_rvalid = 1'b0; s_arready = 1'b0;

        // ---- N=4 pointer wrap ----
        m4_arvalid = 4'b1000; m4_araddr[3] = 64'h3000; m4_araddr[0] = 64'h1000;
        s4_arready = 1'b1; m4_rready = 4'hF;
        tick();
        chk("n4_m3_grant", m4_arready, 4'b1000);
        tick();
        m4_arvalid = 4'b1001; s4_rvalid = 1'b1; #1;
        chk("n4_m3_rvalid", m4_rvalid, 4'b1000);
        tick();
        tick();
        chk("n4_wrap_grant",  m4_arready, 4'b0001);
        chk("n4_wrap_araddr", s4_araddr,  64'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
